// File: rtl/status_pkg.sv
// Shared types, segment constants and the per-state message table for status_display.
package status_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } mode_t;

  typedef enum logic [4:0] {
    CH_0 = 5'd0,  CH_1 = 5'd1,  CH_2 = 5'd2,  CH_3 = 5'd3,
    CH_4 = 5'd4,  CH_5 = 5'd5,  CH_6 = 5'd6,  CH_7 = 5'd7,
    CH_8 = 5'd8,  CH_9 = 5'd9,  CH_A = 5'd10, CH_B = 5'd11,
    CH_C = 5'd12, CH_D = 5'd13, CH_E = 5'd14, CH_F = 5'd15,
    CH_O = 5'd16, CH_R = 5'd17, CH_T = 5'd18, CH_U = 5'd19,
    CH_N = 5'd20, CH_I = 5'd21, CH_L = 5'd22, CH_DASH = 5'd23,
    CH_BLANK = 5'd24
  } char_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int unsigned IDX_W         = 5;
  localparam int unsigned MSG_LEN_BUSY  = 3;
  localparam int unsigned MSG_LEN_DONE  = 7;
  localparam int unsigned MSG_LEN_ERROR = 7;

  // IDLE reports zero length: it fills every digit and never scrolls
  function automatic logic [IDX_W-1:0] msg_len(input mode_t m);
    case (m)
      BUSY:    msg_len = IDX_W'(MSG_LEN_BUSY);
      DONE:    msg_len = IDX_W'(MSG_LEN_DONE);
      ERROR:   msg_len = IDX_W'(MSG_LEN_ERROR);
      default: msg_len = '0;
    endcase
  endfunction

  function automatic char_t msg_char(input mode_t m, input logic [IDX_W-1:0] idx,
                                     input logic [7:0] err);
    msg_char = CH_BLANK;
    case (m)
      IDLE: msg_char = CH_DASH;
      BUSY: begin
        case (idx)
          5'd0:    msg_char = CH_R;
          5'd1:    msg_char = CH_U;
          5'd2:    msg_char = CH_N;
          default: msg_char = CH_BLANK;
        endcase
      end
      DONE: begin
        case (idx)
          5'd0:    msg_char = CH_C;
          5'd1:    msg_char = CH_O;
          5'd2:    msg_char = CH_R;
          5'd3:    msg_char = CH_R;
          5'd4:    msg_char = CH_E;
          5'd5:    msg_char = CH_C;
          5'd6:    msg_char = CH_T;
          default: msg_char = CH_BLANK;
        endcase
      end
      default: begin
        case (idx)
          5'd0:    msg_char = CH_F;
          5'd1:    msg_char = CH_A;
          5'd2:    msg_char = CH_I;
          5'd3:    msg_char = CH_L;
          5'd5:    msg_char = char_t'(5'({1'b0, err[7:4]}));
          5'd6:    msg_char = char_t'(5'({1'b0, err[3:0]}));
          default: msg_char = CH_BLANK;
        endcase
      end
    endcase
  endfunction

endpackage

// File: rtl/seg_encoder.sv
// Character code to active-low {g,f,e,d,c,b,a} segment pattern, purely combinational.
module seg_encoder
  import status_pkg::*;
(
  input  char_t      ch_i,
  output logic [6:0] seg_o_c
);

  always_comb begin
    seg_o_c = SEG_BLANK;
    case (ch_i)
      CH_0:    seg_o_c = 7'b1000000;
      CH_1:    seg_o_c = 7'b1111001;
      CH_2:    seg_o_c = 7'b0100100;
      CH_3:    seg_o_c = 7'b0110000;
      CH_4:    seg_o_c = 7'b0011001;
      CH_5:    seg_o_c = 7'b0010010;
      CH_6:    seg_o_c = 7'b0000010;
      CH_7:    seg_o_c = 7'b1111000;
      CH_8:    seg_o_c = 7'b0000000;
      CH_9:    seg_o_c = 7'b0010000;
      CH_A:    seg_o_c = 7'b0001000;
      CH_B:    seg_o_c = 7'b0000011;
      CH_C:    seg_o_c = 7'b1000110;
      CH_D:    seg_o_c = 7'b0100001;
      CH_E:    seg_o_c = 7'b0000110;
      CH_F:    seg_o_c = 7'b0001110;
      CH_O:    seg_o_c = 7'b1000000;
      CH_R:    seg_o_c = 7'b0101111;
      CH_T:    seg_o_c = 7'b0001111;
      CH_U:    seg_o_c = 7'b1100011;
      CH_N:    seg_o_c = 7'b0101011;
      CH_I:    seg_o_c = 7'b1111001;
      CH_L:    seg_o_c = 7'b1000111;
      CH_DASH: seg_o_c = SEG_DASH;
      default: seg_o_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/status_display.sv
// Test-status readout for an N-digit active-low 7-segment bank with scrolling messages.
// Optional ERROR blink enabled by defining STATUS_DISPLAY_BLINK_EN.
module status_display
  import status_pkg::*;
#(
  parameter int unsigned NDIGITS  = 8,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    done,
  input  logic                    error,
  input  logic                    clear,
  input  logic [7:0]              err_code,
  output logic [NDIGITS-1:0][6:0] seg,
  output mode_t                   mode
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  mode_t                   state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        pos_q, pos_d;
  logic [7:0]              err_q, err_d;
  logic [NDIGITS-1:0][6:0] seg_q, seg_nx;
  logic                    chg_c, tick_c, scroll_c;
  logic [IDX_W-1:0]        len_c, idx_c;
  char_t                   chars [NDIGITS];
`ifdef STATUS_DISPLAY_BLINK_EN
  logic                    phase_q, phase_d;
`endif

  // Next state in priority order, plus divider/scroll/error-latch updates
  always_comb begin
    state_d = state_q;
    if (error)                                         state_d = ERROR;
    else if (clear)                                    state_d = IDLE;
    else if (done && (state_q == IDLE || state_q == BUSY)) state_d = DONE;
    else if (start && state_q == IDLE)                 state_d = BUSY;

    chg_c    = (state_d != state_q);
    tick_c   = (div_q == DIV_W'(TICK_DIV - 1));
    len_c    = msg_len(state_q);
    scroll_c = (32'(len_c) > NDIGITS);

    div_d = div_q + DIV_W'(1);
    if (chg_c || tick_c) div_d = '0;

    pos_d = pos_q;
    if (chg_c)                  pos_d = '0;
    else if (tick_c && scroll_c) pos_d = (pos_q == len_c) ? '0 : pos_q + IDX_W'(1);

    err_d = err_q;
    if (chg_c && state_d == ERROR) err_d = err_code;

`ifdef STATUS_DISPLAY_BLINK_EN
    phase_d = phase_q;
    if (chg_c && state_d == ERROR)        phase_d = 1'b1;
    else if (state_q == ERROR && tick_c)  phase_d = ~phase_q;
`endif
  end

  // Character per digit, index 0 leftmost; scrolling windows over message plus one blank gap
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      idx_c = IDX_W'(i);
      if (scroll_c) begin
        idx_c = pos_q + IDX_W'(i);
        if (idx_c > len_c) idx_c = idx_c - len_c - IDX_W'(1);
      end
      chars[i] = msg_char(state_q, idx_c, err_q);
`ifdef STATUS_DISPLAY_BLINK_EN
      if (state_q == ERROR && !phase_q) chars[i] = CH_BLANK;
`endif
    end
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    seg_encoder u_enc (
      .ch_i    (chars[g]),
      .seg_o_c (seg_nx[NDIGITS-1-g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      pos_q   <= '0;
      err_q   <= '0;
      seg_q   <= {NDIGITS{SEG_BLANK}};
`ifdef STATUS_DISPLAY_BLINK_EN
      phase_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      seg_q   <= seg_nx;
`ifdef STATUS_DISPLAY_BLINK_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign seg  = seg_q;
  assign mode = state_q;

endmodule
